// File: rtl/astro_pkg.sv
// Shared encodings, screen limits and helpers for the astro game engine.
// Imported by the top and the per-target sub-module.
package astro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_WON  = 2'b10,
    ST_LOST = 2'b11
  } game_state_t;

  localparam logic [9:0] SHIP_MIN  = 10'd30;
  localparam logic [9:0] SHIP_MAX  = 10'd610;
  localparam logic [9:0] TGT_MIN   = 10'd200;
  localparam logic [9:0] TGT_MAX   = 10'd400;
  localparam logic [9:0] SHOT_Y0   = 10'd450;
  localparam logic [9:0] SHIP_STEP = 10'd2;
  localparam logic [9:0] SHIP_X0   = 10'd400;

  localparam int TGT_X0 = 200;
  localparam int TGT_DX = 40;
  localparam int TGT_Y0 = 80;
  localparam int TGT_DY = 40;

  // |a-b| <= half, done in 11 bits without any subtraction
  function automatic logic near(
    input logic [9:0]  a,
    input logic [9:0]  b,
    input logic [10:0] half
  );
    logic [10:0] ea;
    logic [10:0] eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return (ea + half >= eb) && (ea <= eb + half);
  endfunction

endpackage

// File: rtl/astro_target.sv
// One bouncing target: position, direction, alive flag and hit test.
// The hit test looks only at pre-tick registered positions.
module astro_target
  import astro_pkg::*;
#(
  parameter int IDX      = 0,
  parameter int TGT_STEP = 2,
  parameter int HIT_HALF = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       run,
  input  logic       kill,
  input  logic       shot_check,
  input  logic [9:0] shot_x,
  input  logic [9:0] shot_y,
  output logic [9:0] x,
  output logic       alive,
  output logic       hit
);

  localparam logic [9:0]  X_INIT = 10'(TGT_X0 + TGT_DX * IDX);
  localparam logic [9:0]  Y_POS  = 10'(TGT_Y0 + TGT_DY * IDX);
  localparam logic [10:0] STEP11 = 11'(TGT_STEP);
  localparam logic [10:0] HALF11 = 11'(HIT_HALF);
  localparam logic        DIR0   = (IDX % 2) == 0;

  logic dir_right;
  logic [10:0] x11;

  assign x11 = {1'b0, x};

  // Hit box test against the in-flight shot
  always_comb begin
    hit = alive & shot_check
        & near(shot_x, x, HALF11)
        & near(shot_y, Y_POS, HALF11);
  end

  // Bounce inside [TGT_MIN,TGT_MAX]; a killed target freezes on its kill tick
  always_ff @(posedge clk) begin
    if (reset || load) begin
      x         <= X_INIT;
      alive     <= 1'b1;
      dir_right <= DIR0;
    end else if (run) begin
      if (kill) begin
        alive <= 1'b0;
      end else if (alive) begin
        if (dir_right) begin
          if (x11 + STEP11 > {1'b0, TGT_MAX}) begin
            dir_right <= 1'b0;
            x <= x - 10'(TGT_STEP);
          end else begin
            x <= x + 10'(TGT_STEP);
          end
        end else begin
          if (x11 < {1'b0, TGT_MIN} + STEP11) begin
            dir_right <= 1'b1;
            x <= x + 10'(TGT_STEP);
          end else begin
            x <= x - 10'(TGT_STEP);
          end
        end
      end
    end
  end

endmodule

// File: rtl/astro_game_engine.sv
// Tick-driven shooter: ship, single shot, NUM_TARGETS targets, game FSM.
// Everything advances only on tick; reset is synchronous and immediate.
module astro_game_engine
  import astro_pkg::*;
#(
  parameter int NUM_TARGETS    = 3,
  parameter int SHOTS_PER_GAME = 8,
  parameter int TGT_STEP       = 2,
  parameter int SHOT_STEP      = 10,
  parameter int HIT_HALF       = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic                      btn_left,
  input  logic                      btn_right,
  input  logic                      btn_fire,
  input  logic                      start,
  output logic [9:0]                ship_x,
  output logic                      shot_active,
  output logic [9:0]                shot_x,
  output logic [9:0]                shot_y,
  output logic [10*NUM_TARGETS-1:0] target_x,
  output logic [NUM_TARGETS-1:0]    target_alive,
  output logic [3:0]                score,
  output logic [3:0]                shots_left,
  output logic [1:0]                state
);

  game_state_t state_q;
  game_state_t state_d;

  logic                   load;
  logic                   run;
  logic                   shot_check;
  logic                   fire;
  logic                   any_hit;
  logic                   found;
  logic [NUM_TARGETS-1:0] hits;
  logic [NUM_TARGETS-1:0] kill;

  assign state      = state_q;
  assign load       = tick & (state_q == ST_IDLE) & start;
  assign run        = tick & (state_q == ST_PLAY);
  assign shot_check = shot_active & (state_q == ST_PLAY);
  assign fire       = btn_fire & ~btn_left & ~btn_right;
  assign any_hit    = |hits;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TARGETS; gi++) begin : g_tgt
      astro_target #(
        .IDX      (gi),
        .TGT_STEP (TGT_STEP),
        .HIT_HALF (HIT_HALF)
      ) u_tgt (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .run        (run),
        .kill       (kill[gi]),
        .shot_check (shot_check),
        .shot_x     (shot_x),
        .shot_y     (shot_y),
        .x          (target_x[10*gi +: 10]),
        .alive      (target_alive[gi]),
        .hit        (hits[gi])
      );
    end
  endgenerate

  // Lowest-index hit wins; only one kill per tick
  always_comb begin
    kill  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (hits[i] && !found) begin
        kill[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  // Game state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: WON takes priority over LOST
  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case (state_q)
        ST_IDLE: if (start) state_d = ST_PLAY;
        ST_PLAY: begin
          if (target_alive == '0)
            state_d = ST_WON;
          else if (shots_left == 4'd0 && !shot_active)
            state_d = ST_LOST;
        end
        ST_WON,
        ST_LOST: if (!start) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Ship, shot, score and ammo datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      ship_x      <= SHIP_X0;
      shot_active <= 1'b0;
      shot_x      <= '0;
      shot_y      <= '0;
      score       <= '0;
      shots_left  <= 4'(SHOTS_PER_GAME);
    end else if (load) begin
      ship_x      <= SHIP_X0;
      shot_active <= 1'b0;
      score       <= '0;
      shots_left  <= 4'(SHOTS_PER_GAME);
    end else if (run) begin
      if (btn_right && !btn_left && ship_x < SHIP_MAX)
        ship_x <= ship_x + SHIP_STEP;
      else if (btn_left && !btn_right && ship_x > SHIP_MIN)
        ship_x <= ship_x - SHIP_STEP;
      if (shot_active) begin
        if (any_hit) begin
          shot_active <= 1'b0;
          if (score != 4'hF) score <= score + 4'd1;
        end else if (shot_y < 10'(SHOT_STEP)) begin
          shot_active <= 1'b0;
        end else begin
          shot_y <= shot_y - 10'(SHOT_STEP);
        end
      end else if (fire && shots_left != 4'd0) begin
        shot_active <= 1'b1;
        shot_x      <= ship_x;
        shot_y      <= SHOT_Y0;
        shots_left  <= shots_left - 4'd1;
      end
    end
  end

endmodule

// File: doc/astro_game_engine.md
ASTRO_GAME_ENGINE -- requirements
Module: astro_game_engine

Interface
REQ-001 Parameter NUM_TARGETS, default 3: number of independent targets (range 1-4).
REQ-002 Parameter SHOTS_PER_GAME, default 8: shots available per game (range 1-15).
REQ-003 Parameter TGT_STEP, default 2: target x-increment per tick.
REQ-004 Parameter SHOT_STEP, default 10: shot y-decrement per tick.
REQ-005 Parameter HIT_HALF, default 10: hit-box half-size in pixels.
REQ-006 clk  in  1  single system clock; all logic rising-edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 tick  in  1  one-cycle game-step enable; state changes only on tick cycles, except reset.
REQ-009 btn_left, btn_right, btn_fire, start  in  1 each  debounced user controls.
REQ-010 ship_x  out  10  ship centre x.
REQ-011 shot_active  out  1; shot_x, shot_y  out  10 each  projectile state.
REQ-012 target_x  out  10*NUM_TARGETS  packed; target i at bits [10i+9:10i].
REQ-013 target_alive  out  NUM_TARGETS  one bit per target.
REQ-014 score  out  4; shots_left  out  4; state  out  2.

Function
REQ-015 All outputs are registered and reflect a tick one cycle after the tick cycle.
REQ-016 States: IDLE=00, PLAY=01, WON=10, LOST=11.
REQ-017 IDLE: on tick with start=1 -> PLAY; load ship_x=400, shot_active=0, score=0, shots_left=SHOTS_PER_GAME, all targets alive, target i x=200+40i, even i moving right, odd i moving left.
REQ-018 Target i y is fixed at 80+40i.
REQ-019 PLAY, ship: btn_right&~btn_left and ship_x<610 -> +2; btn_left&~btn_right and ship_x>30 -> -2; both or neither -> hold.
REQ-020 PLAY, fire: btn_fire&~btn_left&~btn_right, shot_active=0, shots_left>0 -> shot_active=1, shot_x=ship_x, shot_y=450, shots_left-1; fire while active or with shots_left=0 is ignored.
REQ-021 Live targets move TGT_STEP per tick within [200,400]; moving right with x+TGT_STEP>400 -> reverse, x-=TGT_STEP; mirrored at 200; dead targets freeze.
REQ-022 Active shot (not on its launch tick): hit test first, using pre-tick positions; else shot_y<SHOT_STEP -> shot_active=0; else shot_y-=SHOT_STEP.
REQ-023 Hit: target alive, |shot_x-tx|<=HIT_HALF, |shot_y-ty|<=HIT_HALF; computed in 11-bit unsigned as a+HIT_HALF>=b && a<=b+HIT_HALF, no underflow.
REQ-024 On hit: lowest-index hit target cleared, shot_active=0, score+1 saturating at 15; at most one kill per tick.
REQ-025 PLAY -> WON on the tick after target_alive becomes all-zero.
REQ-026 PLAY -> LOST on a tick with shots_left=0, shot_active=0, any target alive; WON is checked first.
REQ-027 WON/LOST: all positions, score frozen; on tick with start=0 -> IDLE; IDLE holds last values.
REQ-028 start dropping during PLAY has no effect.

Reset
REQ-029 reset forces, regardless of tick: state=IDLE, ship_x=400, shot_active=0, shot_x=0, shot_y=0, score=0, shots_left=SHOTS_PER_GAME, target_alive=all ones, target i x=200+40i.
REQ-030 Reset mid-shot or mid-game aborts immediately; no partial scoring survives.

Structure
REQ-031 Package astro_pkg holds state encodings, screen limits (30, 610, 200, 400, 450), ship step and start positions.
REQ-032 Sub-module astro_target (one target: x, direction, alive, kill input, hit-test output), instantiated NUM_TARGETS times via generate; priority select in the parent.

Verification
REQ-033 reset, start=1, one tick -> state=01, ship_x=400, target_x[0]=200, target_x[1]=240, shots_left=8.
REQ-034 btn_right held 110 ticks from 400 -> ship_x stops at 610; btn_left+btn_right -> ship_x unchanged.
REQ-035 Target 0 at x=398 moving right, tick -> 400 then 398 next tick (reversed); dead target x unchanged over 10 ticks.
REQ-036 Fire with ship_x=200, target 0 at x=200 (forced), shot passes y=80 band -> target_alive[0]=0, score=1, shot_active=0 same tick; btn_fire during flight -> shots_left unchanged.
REQ-037 Fire 8 shots that all miss -> shots_left=0, after last shot expires (shot_y<10) state=11; start=0, tick -> state=00.
REQ-038 reset asserted with shot_active=1 and score=2 -> next cycle state=00, score=0, shot_active=0, without tick.
